// File: rtl/frame_scanout.sv
// Purpose: VGA-style raster timing plus 2x2-doubled scanout of a half-resolution framebuffer.
// Latency: RD_LAT+2 cycles from counter value to visible pixel; frame_start/line_count undelayed.
// Backpressure: none; pixel clock free-runs and the framebuffer read latency is fixed at RD_LAT.
module frame_scanout #(
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [17:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        frame_start,
  output logic [9:0]  line_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DLY     = RD_LAT + 1;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Framebuffer row stride: one stored pixel per two displayed columns.
  localparam logic [17:0] FB_W   = 18'(H_ACTIVE / 2);

  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        active_c, hs_raw_c, vs_raw_c;
  logic [17:0] rd_addr_q, rd_addr_d;
  // Per stage: bit0 active, bit1 hsync, bit2 vsync (all active-high).
  logic [DLY-1:0][2:0] dly_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_n_q, vs_n_q, fs_q;
  logic        pix_on_c;
  logic        unused_rd_hi;

  // Raster counter advance, timing decode and doubled-pixel address.
  always_comb begin
    hc_d      = (hc_q == H_MAX) ? 11'd0 : hc_q + 11'd1;
    vc_d      = vc_q;
    if (hc_q == H_MAX) begin
      vc_d = (vc_q == V_MAX) ? 10'd0 : vc_q + 10'd1;
    end
    active_c  = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs_raw_c  = (hc_q >= HS_BEG) && (hc_q < HS_END);
    vs_raw_c  = (vc_q >= VS_BEG) && (vc_q < VS_END);
    rd_addr_d = 18'd0;
    if (active_c) begin
      rd_addr_d = 18'(vc_q[9:1]) * FB_W + 18'(hc_q[10:1]);
    end
  end

  // Output stage: enable is only looked at here, so timing never depends on it.
  always_comb begin
    pix_on_c = dly_q[DLY-1][0] && enable;
    rgb_d    = pix_on_c ? rd_data[11:0] : 12'h000;
  end

  assign unused_rd_hi = ^rd_data[15:12];

  // Raster counters, read address and one-cycle frame_start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q      <= 11'd0;
      vc_q      <= 10'd0;
      rd_addr_q <= 18'd0;
      fs_q      <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      rd_addr_q <= rd_addr_d;
      fs_q      <= (hc_q == 11'd0) && (vc_q == 10'd0);
    end
  end

  // Delay active/syncs so they meet the read data issued for the same counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= {vs_raw_c, hs_raw_c, active_c};
      for (int i = 1; i < DLY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Colour and sync output registers, updated every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= 12'h000;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
    end else begin
      rgb_q  <= rgb_d;
      hs_n_q <= ~dly_q[DLY-1][1];
      vs_n_q <= ~dly_q[DLY-1][2];
    end
  end

  assign rd_addr     = rd_addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs_n    = hs_n_q;
  assign vga_vs_n    = vs_n_q;
  assign frame_start = fs_q;
  assign line_count  = vc_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Purpose: randomized-enable bench for frame_scanout on a reduced raster, against an arithmetic model.
// Latency: expects pixels RD_LAT+2 cycles after the counter value, frame_start one cycle after (0,0).
// Backpressure: none; a latency-RD_LAT framebuffer model drives X for blanking reads.
module tb_frame_scanout;
  localparam int RD_LAT = 2;
  localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VS = 3, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int L = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] rd_data;
  logic [17:0] rd_addr;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs_n, vga_vs_n, frame_start;
  logic [9:0]  line_count;

  frame_scanout #(
    .RD_LAT(RD_LAT), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n),
    .frame_start(frame_start), .line_count(line_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n = 0;
  int run_id = 0;
  logic [17:0] ra_h [8];
  bit          en_h [8];
  int fs_cnt [2];
  int hs_cnt [2];
  int vs_cnt [2];
  int nz_cnt [2];

  // Reference model: cycle n after reset release shows counter value n.
  function automatic int hc_of(input int c); return c % HT; endfunction
  function automatic int vc_of(input int c); return (c / HT) % VT; endfunction
  function automatic bit act_of(input int c); return hc_of(c) < HA && vc_of(c) < VA; endfunction
  function automatic bit hs_of(input int c);
    return hc_of(c) >= HA + HFP && hc_of(c) < HA + HFP + HS;
  endfunction
  function automatic bit vs_of(input int c);
    return vc_of(c) >= VA + VFP && vc_of(c) < VA + VFP + VS;
  endfunction
  function automatic int addr_of(input int c);
    return (vc_of(c) / 2) * (HA / 2) + hc_of(c) / 2;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (run %0d cycle %0d)", tag, got, exp, run_id, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_addr"}, 32'(rd_addr), 0);
    check_val({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
    check_val({tag, "_hs"}, 32'(vga_hs_n), 1);
    check_val({tag, "_vs"}, 32'(vga_vs_n), 1);
    check_val({tag, "_fs"}, 32'(frame_start), 0);
    check_val({tag, "_lc"}, 32'(line_count), 0);
  endtask

  task automatic check_cycle();
    logic [17:0] ea;
    logic [11:0] ec;
    bit ehs, evs, efs, en_prev;
    int m, p, w;
    m = n - 1;
    p = n - L;
    ea  = (n >= 1 && act_of(m)) ? 18'(addr_of(m)) : 18'd0;
    efs = (n >= 1) && hc_of(m) == 0 && vc_of(m) == 0;
    ehs = (n >= L) ? !hs_of(p) : 1'b1;
    evs = (n >= L) ? !vs_of(p) : 1'b1;
    en_prev = (n >= 1) ? en_h[m % 8] : 1'b0;
    ec  = (n >= L && act_of(p) && en_prev) ? 12'(addr_of(p)) : 12'h000;
    check_val("rd_addr", 32'(rd_addr), 32'(ea));
    check_val("frame_start", 32'(frame_start), 32'(efs));
    check_val("line_count", 32'(line_count), 32'(vc_of(n)));
    check_val("hs_n", 32'(vga_hs_n), 32'(ehs));
    check_val("vs_n", 32'(vga_vs_n), 32'(evs));
    check_val("rgb", 32'({vga_r, vga_g, vga_b}), 32'(ec));
    if (run_id == 0 && n >= 1) begin
      if (hc_of(m) == 2 && vc_of(m) == 0) check_val("addr_h2v0", 32'(rd_addr), 1);
      if (hc_of(m) == 0 && vc_of(m) == 2) check_val("addr_h0v2", 32'(rd_addr), 16);
      if (hc_of(m) == HA-1 && vc_of(m) == VA-1) check_val("addr_last", 32'(rd_addr), 127);
      if ((hc_of(m) == 20 || hc_of(m) == 21) && (vc_of(m) == 10 || vc_of(m) == 11))
        check_val("addr_double", 32'(rd_addr), 90);
    end
    if (run_id == 0 && n >= L && n < L + FRAME) begin
      if (hc_of(p) == 0 && vc_of(p) == 0) check_val("rgb_h0v0", 32'({vga_r, vga_g, vga_b}), 0);
      if (hc_of(p) == 2 && vc_of(p) == 0) check_val("rgb_h2v0", 32'({vga_r, vga_g, vga_b}), 1);
      if (hc_of(p) == 0 && vc_of(p) == 2) check_val("rgb_h0v2", 32'({vga_r, vga_g, vga_b}), 16);
      if (hc_of(p) == HA-1 && vc_of(p) == VA-1)
        check_val("rgb_last", 32'({vga_r, vga_g, vga_b}), 32'h07F);
    end
    if (run_id == 1 && n == 1) check_val("fs_after_rst", 32'(frame_start), 1);
    if (run_id == 0 && n >= L && n < L + 2*FRAME) begin
      w = (n - L) / FRAME;
      fs_cnt[w] += int'(frame_start === 1'b1);
      hs_cnt[w] += int'(vga_hs_n === 1'b0);
      vs_cnt[w] += int'(vga_vs_n === 1'b0);
      nz_cnt[w] += int'({vga_r, vga_g, vga_b} !== 12'h000);
    end
  endtask

  // Record this cycle's address, pick enable, and present framebuffer data for this cycle.
  task automatic post_cycle();
    logic [17:0] a;
    ra_h[n % 8] = rd_addr;
    if (run_id == 0 && n < L + FRAME - 1) enable = 1'b1;
    else if (run_id == 0 && n < L + 2*FRAME - 1) enable = 1'b0;
    else if ($urandom_range(15) == 0) enable = ~enable;
    en_h[n % 8] = enable;
    if (n >= 3 && act_of(n - 3)) begin
      a = ra_h[(n - 2) % 8];
      rd_data = {4'($urandom), a[11:0]};
    end else begin
      rd_data = 16'hxxxx;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_cycle();
    post_cycle();
  endtask

  task automatic start_run();
    n = 0;
    check_cycle();
    post_cycle();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 2; i++) begin
      fs_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0; nz_cnt[i] = 0;
    end
    rd_data = 16'hxxxx;
    #23;
    check_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    repeat (L + 3*FRAME) step();

    check_val("win_a_fs", 32'(fs_cnt[0]), 1);
    check_val("win_a_hs", 32'(hs_cnt[0]), 32'(VT * HS));
    check_val("win_a_vs", 32'(vs_cnt[0]), 32'(VS * HT));
    check_val("win_a_lit", 32'(nz_cnt[0]), 32'(HA * VA - 4));
    check_val("win_b_fs", 32'(fs_cnt[1]), 1);
    check_val("win_b_hs", 32'(hs_cnt[1]), 32'(VT * HS));
    check_val("win_b_vs", 32'(vs_cnt[1]), 32'(VS * HT));
    check_val("win_b_lit", 32'(nz_cnt[1]), 0);

    guard = 0;
    while (!(hc_of(n) == 20 && vc_of(n) == 10) && guard < 2*FRAME) begin
      step();
      guard++;
    end
    check_val("reach_mid", 32'(guard < 2*FRAME), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    rd_data = 16'hxxxx;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_id = 1;
    start_run();
    repeat (FRAME + 100) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "timeout");
  end

endmodule
